// File: rtl/fir_tap_sequencer.sv
// FIR delay-line sequencer: writes each accepted sample into a circular RAM buffer,
// then reads back the NTAPS newest samples (newest first) with framing for the MAC.
module fir_tap_sequencer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int NTAPS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_raddr,
  input  logic [DWIDTH-1:0] ram_q,
  output logic              tap_valid,
  output logic [DWIDTH-1:0] tap_data,
  output logic [AWIDTH-1:0] coef_idx,
  output logic              tap_first,
  output logic              tap_last,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int CWIDTH = AWIDTH + 1;
  localparam logic [CWIDTH-1:0] LAST_K   = CWIDTH'(NTAPS - 1);
  localparam logic [CWIDTH-1:0] FILL_MAX = CWIDTH'(NTAPS);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [AWIDTH-1:0] wptr;
  logic [CWIDTH-1:0] fill;
  logic [CWIDTH-1:0] k;
  logic [DWIDTH-1:0] sample;
  logic              tap_keep;
  logic              handshake;

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign handshake = in_valid && in_ready;

  assign ram_we    = (state == WRITE);
  assign ram_waddr = wptr;
  assign ram_wdata = sample;
  assign ram_re    = (state == READ);
  assign ram_raddr = wptr - k[AWIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = WRITE;
      WRITE:   state_nxt = READ;
      READ:    if (k == LAST_K) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wptr   <= '0;
      fill   <= '0;
      k      <= '0;
      sample <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) sample <= in_data;
      case (state)
        WRITE: begin
          k <= '0;
          if (fill != FILL_MAX) fill <= fill + CWIDTH'(1);
        end
        READ:  if (k != LAST_K) k <= k + CWIDTH'(1);
        DRAIN: begin
          wptr <= wptr + AWIDTH'(1);
          k    <= '0;
        end
        default: ;
      endcase
    end
  end

  // fill was already bumped in WRITE, so the compare here counts the current sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_valid <= 1'b0;
      coef_idx  <= '0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      tap_keep  <= 1'b0;
    end else begin
      tap_valid <= ram_re;
      coef_idx  <= ram_re ? k[AWIDTH-1:0] : '0;
      tap_first <= ram_re && (k == '0);
      tap_last  <= ram_re && (k == LAST_K);
      tap_keep  <= ram_re && (k < fill);
    end
  end

  assign tap_data = tap_keep ? ram_q : '0;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: three instances (NTAPS=4/AWIDTH=8, NTAPS=4/AWIDTH=4,
// NTAPS=1/AWIDTH=3), each with its own RAM, checked against a sample-history model.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       preload;
  logic [2:0] in_valid;
  logic [7:0] in_data [3];
  logic [2:0] rdy, bsy, we, re, tv, tf, tl;
  logic [7:0] wa [3];
  logic [7:0] wd [3];
  logic [7:0] ra [3];
  logic [7:0] td [3];
  logic [7:0] ci [3];

  logic [7:0] a_wa, a_ra, a_ci, a_wd, a_td, a_q;
  logic [3:0] b_wa, b_ra, b_ci;
  logic [7:0] b_wd, b_td, b_q;
  logic [2:0] c_wa, c_ra, c_ci;
  logic [7:0] c_wd, c_td, c_q;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  logic [7:0] mem_c [8];

  int checks = 0;
  int failures = 0;

  logic [7:0] hist [3][1024];
  int         wcnt [3];
  logic [7:0] cap_wa;
  logic [7:0] cap_ra [16];
  logic [7:0] cap_td [16];
  logic       cap_tf [16];
  logic       cap_tl [16];

  fir_tap_sequencer #(.DWIDTH(8), .AWIDTH(8), .NTAPS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]), .in_data(in_data[0]),
    .ram_we(we[0]), .ram_waddr(a_wa), .ram_wdata(a_wd), .ram_re(re[0]), .ram_raddr(a_ra),
    .ram_q(a_q), .tap_valid(tv[0]), .tap_data(a_td), .coef_idx(a_ci), .tap_first(tf[0]),
    .tap_last(tl[0]), .busy(bsy[0]));

  fir_tap_sequencer #(.DWIDTH(8), .AWIDTH(4), .NTAPS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]), .in_data(in_data[1]),
    .ram_we(we[1]), .ram_waddr(b_wa), .ram_wdata(b_wd), .ram_re(re[1]), .ram_raddr(b_ra),
    .ram_q(b_q), .tap_valid(tv[1]), .tap_data(b_td), .coef_idx(b_ci), .tap_first(tf[1]),
    .tap_last(tl[1]), .busy(bsy[1]));

  fir_tap_sequencer #(.DWIDTH(8), .AWIDTH(3), .NTAPS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]), .in_data(in_data[2]),
    .ram_we(we[2]), .ram_waddr(c_wa), .ram_wdata(c_wd), .ram_re(re[2]), .ram_raddr(c_ra),
    .ram_q(c_q), .tap_valid(tv[2]), .tap_data(c_td), .coef_idx(c_ci), .tap_first(tf[2]),
    .tap_last(tl[2]), .busy(bsy[2]));

  assign wa[0] = a_wa;
  assign wa[1] = {4'b0, b_wa};
  assign wa[2] = {5'b0, c_wa};
  assign ra[0] = a_ra;
  assign ra[1] = {4'b0, b_ra};
  assign ra[2] = {5'b0, c_ra};
  assign ci[0] = a_ci;
  assign ci[1] = {4'b0, b_ci};
  assign ci[2] = {5'b0, c_ci};
  assign wd[0] = a_wd;
  assign wd[1] = b_wd;
  assign wd[2] = c_wd;
  assign td[0] = a_td;
  assign td[1] = b_td;
  assign td[2] = c_td;

  // RAMs are preloaded with nonzero junk so that unfilled taps must be masked
  always @(posedge clk) begin
    if (preload) for (int j = 0; j < 256; j++) mem_a[j] <= 8'h80 | 8'(j);
    else if (we[0]) mem_a[a_wa] <= a_wd;
    if (re[0]) a_q <= mem_a[a_ra];
  end

  always @(posedge clk) begin
    if (preload) for (int j = 0; j < 16; j++) mem_b[j] <= 8'h90 | 8'(j);
    else if (we[1]) mem_b[b_wa] <= b_wd;
    if (re[1]) b_q <= mem_b[b_ra];
  end

  always @(posedge clk) begin
    if (preload) for (int j = 0; j < 8; j++) mem_c[j] <= 8'hC0 | 8'(j);
    else if (we[2]) mem_c[c_wa] <= c_wd;
    if (re[2]) c_q <= mem_c[c_ra];
  end

  function automatic int nt(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int aw(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 4 : 3);
  endfunction

  task automatic hold_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
  endtask

  // One full stream on instance i, compared cycle by cycle against the history model.
  task automatic do_stream(input int i, input logic [7:0] s, input int pulse_c, input int stop_c);
    int n, d, a, fm, last, waited, kk, er;
    logic [7:0] etd;
    logic       exp_b;
    n = nt(i);
    d = 1 << aw(i);
    waited = 0;
    @(negedge clk);
    while (rdy[i] !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (rdy[i] !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout inst=%0d got=%b exp=1", i, rdy[i]);
      return;
    end
    in_valid[i] = 1'b1;
    in_data[i]  = s;
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_data[i]  = 8'($urandom);
    hist[i][wcnt[i]] = s;
    a  = wcnt[i] % d;
    fm = (wcnt[i] + 1 < n) ? wcnt[i] + 1 : n;
    last = (stop_c > 0) ? stop_c - 1 : n + 3;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      exp_b = (c == n + 3);
      checks++;
      if (rdy[i] !== exp_b || bsy[i] !== ~exp_b) begin
        failures++;
        $display("FAIL ready inst=%0d c=%0d got=%b/%b exp=%b/%b", i, c, rdy[i], bsy[i], exp_b, ~exp_b);
      end
      exp_b = (c == 1);
      checks++;
      if (we[i] !== exp_b) begin
        failures++;
        $display("FAIL ram_we inst=%0d c=%0d got=%b exp=%b", i, c, we[i], exp_b);
      end
      if (c == 1) begin
        cap_wa = wa[i];
        checks++;
        if (wa[i] !== 8'(a) || wd[i] !== s) begin
          failures++;
          $display("FAIL write inst=%0d got=%0h@%0h exp=%0h@%0h", i, wd[i], wa[i], s, a);
        end
      end
      exp_b = (c >= 2 && c <= n + 1);
      checks++;
      if (re[i] !== exp_b) begin
        failures++;
        $display("FAIL ram_re inst=%0d c=%0d got=%b exp=%b", i, c, re[i], exp_b);
      end
      if (exp_b) begin
        kk = c - 2;
        er = ((a - kk) % d + d) % d;
        cap_ra[kk] = ra[i];
        checks++;
        if (ra[i] !== 8'(er)) begin
          failures++;
          $display("FAIL raddr inst=%0d k=%0d got=%0h exp=%0h", i, kk, ra[i], er);
        end
      end
      exp_b = (c >= 3 && c <= n + 2);
      checks++;
      if (tv[i] !== exp_b) begin
        failures++;
        $display("FAIL tap_valid inst=%0d c=%0d got=%b exp=%b", i, c, tv[i], exp_b);
      end
      if (exp_b) begin
        kk = c - 3;
        etd = (kk < fm) ? hist[i][wcnt[i] - kk] : 8'h00;
        cap_td[kk] = td[i];
        cap_tf[kk] = tf[i];
        cap_tl[kk] = tl[i];
        checks++;
        if (td[i] !== etd || ci[i] !== 8'(kk)) begin
          failures++;
          $display("FAIL tap inst=%0d k=%0d got=%0h idx=%0d exp=%0h idx=%0d", i, kk, td[i], ci[i], etd, kk);
        end
        checks++;
        if (tf[i] !== (kk == 0) || tl[i] !== (kk == n - 1)) begin
          failures++;
          $display("FAIL framing inst=%0d k=%0d got=%b%b exp=%b%b", i, kk, tf[i], tl[i], kk == 0, kk == n - 1);
        end
      end else begin
        checks++;
        if (tl[i] !== 1'b0) begin
          failures++;
          $display("FAIL stray_last inst=%0d c=%0d got=%b exp=0", i, c, tl[i]);
        end
      end
      if (c == pulse_c) begin
        in_valid[i] = 1'b1;
        in_data[i]  = 8'h55;
      end else if (pulse_c > 0 && c == pulse_c + 1) begin
        in_valid[i] = 1'b0;
      end
    end
    in_valid[i] = 1'b0;
    wcnt[i]++;
  endtask

  task automatic test_reset;
    logic [46:0] got;
    logic [7:0]  er [4] = '{8'h00, 8'hFF, 8'hFE, 8'hFD};
    logic [7:0]  et [4] = '{8'h11, 8'h00, 8'h00, 8'h00};
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {rdy[i], bsy[i], we[i], re[i], tv[i], tf[i], tl[i], wa[i], wd[i], ra[i], td[i], ci[i]};
      checks++;
      if (got !== {1'b1, 46'b0}) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%h exp=%h", i, got, {1'b1, 46'b0});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
    do_stream(0, 8'h11, 0, 0);
    checks++;
    if (cap_wa !== 8'h00) begin
      failures++;
      $display("FAIL first_waddr got=%0h exp=0", cap_wa);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_ra[k] !== er[k] || cap_td[k] !== et[k]) begin
        failures++;
        $display("FAIL first_stream k=%0d got=%0h/%0h exp=%0h/%0h", k, cap_ra[k], cap_td[k], er[k], et[k]);
      end
    end
  endtask

  task automatic test_fill;
    logic [7:0] e3 [4] = '{8'h03, 8'h02, 8'h01, 8'h00};
    logic [7:0] e5 [4] = '{8'h05, 8'h04, 8'h03, 8'h02};
    hold_reset();
    for (int n = 1; n <= 5; n++) begin
      do_stream(0, 8'(n), 0, 0);
      if (n == 3 || n == 5) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (cap_td[k] !== ((n == 3) ? e3[k] : e5[k])) begin
            failures++;
            $display("FAIL fill_stream%0d k=%0d got=%0h exp=%0h", n, k, cap_td[k], (n == 3) ? e3[k] : e5[k]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_stream(0, 8'($urandom), 0, 0);
    end
  endtask

  task automatic test_ignored_input;
    do_stream(0, 8'($urandom), 3, 0);
    @(negedge clk);
    checks++;
    if (we[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL ignored_input got=we%b rdy%b exp=we0 rdy1", we[0], rdy[0]);
    end
  endtask

  task automatic test_back_to_back;
    int prev, acc, w;
    prev = -100;
    acc = 0;
    @(negedge clk);
    in_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      in_data[0] = 8'($urandom);
      checks++;
      if (rdy[0] !== ~bsy[0]) begin
        failures++;
        $display("FAIL ready_busy cyc=%0d got=%b/%b exp=complementary", cyc, rdy[0], bsy[0]);
      end
      checks++;
      if (we[0] !== (cyc == prev + 1)) begin
        failures++;
        $display("FAIL b2b_we cyc=%0d got=%b exp=%b", cyc, we[0], cyc == prev + 1);
      end
      if (cyc == prev + 1) begin
        checks++;
        if (wd[0] !== hist[0][wcnt[0] - 1] || wa[0] !== 8'((wcnt[0] - 1) % 256)) begin
          failures++;
          $display("FAIL b2b_write got=%0h@%0h exp=%0h@%0h", wd[0], wa[0], hist[0][wcnt[0] - 1], (wcnt[0] - 1) % 256);
        end
      end
      if (rdy[0] === 1'b1) begin
        if (acc > 0) begin
          checks++;
          if (cyc - prev != 7) begin
            failures++;
            $display("FAIL accept_gap got=%0d exp=7", cyc - prev);
          end
        end
        hist[0][wcnt[0]] = in_data[0];
        wcnt[0]++;
        prev = cyc;
        acc++;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    w = 0;
    while (rdy[0] !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (acc != 7 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL accept_count got=%0d rdy=%b exp=7 rdy=1", acc, rdy[0]);
    end
  endtask

  task automatic test_mid_reset;
    logic [46:0] got;
    do_stream(0, 8'($urandom), 0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {rdy[0], bsy[0], we[0], re[0], tv[0], tf[0], tl[0], wa[0], wd[0], ra[0], td[0], ci[0]};
    checks++;
    if (got !== {1'b1, 46'b0}) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=%h", got, {1'b1, 46'b0});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (tl[0] !== 1'b0 || tv[0] !== 1'b0) begin
        failures++;
        $display("FAIL midreset_tap c=%0d got=v%b l%b exp=v0 l0", c, tv[0], tl[0]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
    do_stream(0, 8'hAA, 0, 0);
    checks++;
    if (cap_wa !== 8'h00) begin
      failures++;
      $display("FAIL midreset_waddr got=%0h exp=0", cap_wa);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_td[k] !== ((k == 0) ? 8'hAA : 8'h00)) begin
        failures++;
        $display("FAIL midreset_tap k=%0d got=%0h exp=%0h", k, cap_td[k], (k == 0) ? 8'hAA : 8'h00);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] er [4] = '{8'd0, 8'd15, 8'd14, 8'd13};
    logic [7:0] et [4] = '{8'd17, 8'd16, 8'd15, 8'd14};
    hold_reset();
    for (int n = 1; n <= 20; n++) begin
      do_stream(1, 8'(n), 0, 0);
      if (n == 17) begin
        checks++;
        if (cap_wa !== 8'd0) begin
          failures++;
          $display("FAIL wrap_waddr got=%0d exp=0", cap_wa);
        end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (cap_ra[k] !== er[k] || cap_td[k] !== et[k]) begin
            failures++;
            $display("FAIL wrap_k%0d got=%0d/%0d exp=%0d/%0d", k, cap_ra[k], cap_td[k], er[k], et[k]);
          end
        end
      end
    end
  endtask

  task automatic test_ntaps1;
    for (int n = 0; n < 10; n++) begin
      do_stream(2, 8'($urandom), 0, 0);
      checks++;
      if (cap_tf[0] !== 1'b1 || cap_tl[0] !== 1'b1) begin
        failures++;
        $display("FAIL ntaps1_framing got=%b%b exp=11", cap_tf[0], cap_tl[0]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    preload  = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      in_data[i] = '0;
      wcnt[i]    = 0;
    end
    test_reset();
    test_fill();
    test_random();
    test_ignored_input();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    test_ntaps1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
